conv_pe_sequencer: RTL

Control FSM that sequences one convolution layer through the 16-PE cluster, the IFM/weight BRAMs and the address generator. It loads per-layer geometry on `start` and computes the MAC beat count per output window. It then walks every output pixel and every 16-filter group, drives the PE reset/finish pulses and collects the cluster result. Each result goes out on a valid/ready stream, so backpressure stalls the array. It sits between the layer-level host controller and the convolution sub-top.

---
 rtl/conv_seq_pkg.sv | 27 ++
 rtl/conv_seq_counters.sv | 54 +++++
 rtl/conv_pe_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution PE sequencer.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_FLUSH,
        S_DRAIN,
        S_OUT,
        S_NEXT
    } conv_seq_state_e;

    localparam int unsigned NUM_PE_DEFAULT = 16;
    localparam int unsigned K_MAX          = 7;
    localparam int unsigned TIMEOUT_LIMIT  = 4096;

    // MAC beats per output window: K*K*C/4. The channel count is a multiple
    // of 4, so dividing it first keeps the intermediate product small.
    function automatic logic [31:0] beats_f(input logic [3:0]  k,
                                            input logic [11:0] ifm_c);
        logic [31:0] kk;
        kk = 32'(k) * 32'(k);
        return kk * 32'(ifm_c[11:2]);
    endfunction

endpackage

// File: rtl/conv_seq_counters.sv
// Beat, pixel and group counters for the convolution PE sequencer.
module conv_seq_counters #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             beat_clr,
    input  logic             beat_inc,
    input  logic             pix_adv,
    input  logic [CNT_W-1:0] beats,
    input  logic [CNT_W-1:0] pix_total,
    input  logic [CNT_W-1:0] grp_total,
    output logic [CNT_W-1:0] beat_cnt,
    output logic [CNT_W-1:0] pixel,
    output logic [CNT_W-1:0] group,
    output logic             beat_last,
    output logic             pix_last,
    output logic             grp_last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    assign beat_last = (beat_cnt == beats - ONE);
    assign pix_last  = (pixel == pix_total - ONE);
    assign grp_last  = (group == grp_total - ONE);

    // Beat counter: shared by ACCUM (MAC beats) and FLUSH (BRAM latency).
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            beat_cnt <= '0;
        end else if (beat_clr) begin
            beat_cnt <= '0;
        end else if (beat_inc) begin
            beat_cnt <= beat_cnt + ONE;
        end
    end

    // Pixel is the inner loop; group advances when pixel wraps.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            pixel <= '0;
            group <= '0;
        end else if (pix_adv) begin
            if (pix_last) begin
                pixel <= '0;
                group <= group + ONE;
            end else begin
                pixel <= pixel + ONE;
            end
        end
    end

endmodule

// File: rtl/conv_pe_sequencer.sv
// Convolution layer sequencer: walks output pixels and filter groups through
// the PE cluster and streams each window result out on valid/ready.
// Optional: define CONV_SEQ_TIMEOUT_EN for the DRAIN watchdog and timeout_err.
module conv_pe_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned NUM_PE   = NUM_PE_DEFAULT,
    parameter int unsigned BRAM_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [3:0]          cfg_kernel_w,
    input  logic [11:0]         cfg_ifm_c,
    input  logic [11:0]         cfg_ofm_w,
    input  logic [11:0]         cfg_ofm_h,
    input  logic [11:0]         cfg_ofm_c,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output logic                ag_ready,
    output logic                ag_step,
    output logic [NUM_PE-1:0]   PE_reset,
    output logic [NUM_PE-1:0]   PE_finish,
    input  logic [NUM_PE-1:0]   pe_valid,
    input  logic [8*NUM_PE-1:0] pe_ofm,
    output logic [8*NUM_PE-1:0] ofm_data,
    output logic                ofm_valid,
    input  logic                ofm_ready,
    output logic [CNT_W-1:0]    ofm_pixel,
    output logic [CNT_W-1:0]    ofm_group
`ifdef CONV_SEQ_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    conv_seq_state_e  state_q, state_d;
    logic             cfg_ok, accept;
    logic             beat_clr, beat_inc, pix_adv, capture, handshake;
    logic             beat_last, pix_last, grp_last, last_win, flush_last;
    logic             wd_expired, done_q;
    logic [CNT_W-1:0] beats_q, pix_total_q, grp_total_q, beat_cnt;

    assign cfg_ok = (cfg_kernel_w != 4'd0) && (32'(cfg_kernel_w) <= K_MAX) &&
                    (cfg_ifm_c != '0) && (cfg_ifm_c[1:0] == 2'b00) &&
                    (cfg_ofm_w != '0) && (cfg_ofm_h != '0) && (cfg_ofm_c != '0) &&
                    ((32'(cfg_ofm_c) % NUM_PE) == 32'd0);

    assign accept     = (state_q == S_IDLE) && start && !abort;
    assign last_win   = pix_last && grp_last;
    assign flush_last = (beat_cnt == CNT_W'(BRAM_LAT - 1));
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;

    conv_seq_counters #(
        .CNT_W (CNT_W)
    ) u_counters (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (state_d == S_IDLE),
        .beat_clr  (beat_clr),
        .beat_inc  (beat_inc),
        .pix_adv   (pix_adv),
        .beats     (beats_q),
        .pix_total (pix_total_q),
        .grp_total (grp_total_q),
        .beat_cnt  (beat_cnt),
        .pixel     (ofm_pixel),
        .group     (ofm_group),
        .beat_last (beat_last),
        .pix_last  (pix_last),
        .grp_last  (grp_last)
    );

    // Next-state and per-state control strobes; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        ag_ready  = 1'b0;
        ag_step   = 1'b0;
        PE_reset  = '0;
        PE_finish = '0;
        ofm_valid = 1'b0;
        beat_clr  = 1'b0;
        beat_inc  = 1'b0;
        pix_adv   = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        unique case (state_q)
            S_IDLE:  if (start && cfg_ok) state_d = S_LOAD;
            S_LOAD: begin
                PE_reset = '1;
                beat_clr = 1'b1;
                state_d  = S_ACCUM;
            end
            S_ACCUM: begin
                ag_ready = 1'b1;
                ag_step  = 1'b1;
                if (beat_last) begin
                    beat_clr = 1'b1;
                    state_d  = S_FLUSH;
                end else begin
                    beat_inc = 1'b1;
                end
            end
            S_FLUSH: begin
                if (flush_last) begin
                    PE_finish = '1;
                    state_d   = S_DRAIN;
                end else begin
                    beat_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                if (&pe_valid) begin
                    capture = 1'b1;
                    state_d = S_OUT;
                end else if (wd_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                ofm_valid = 1'b1;
                if (ofm_ready) begin
                    handshake = 1'b1;
                    state_d   = last_win ? S_IDLE : S_NEXT;
                end
            end
            S_NEXT: begin
                pix_adv = 1'b1;
                state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            capture   = 1'b0;
            handshake = 1'b0;
            pix_adv   = 1'b0;
        end
    end

    // State register, done pulse and config error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= handshake && last_win;
            if (accept) cfg_err <= !cfg_ok;
        end
    end

    // Layer geometry latched on a legal start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beats_q     <= '0;
            pix_total_q <= '0;
            grp_total_q <= '0;
        end else if (accept && cfg_ok) begin
            beats_q     <= CNT_W'(beats_f(cfg_kernel_w, cfg_ifm_c));
            pix_total_q <= CNT_W'(32'(cfg_ofm_w) * 32'(cfg_ofm_h));
            grp_total_q <= CNT_W'(32'(cfg_ofm_c) / NUM_PE);
        end
    end

    // Result capture; cleared whenever the sequencer drops back to IDLE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ofm_data <= '0;
        end else if (capture) begin
            ofm_data <= pe_ofm;
        end else if (state_d == S_IDLE) begin
            ofm_data <= '0;
        end
    end

`ifdef CONV_SEQ_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign wd_expired = (wd_cnt == 16'(TIMEOUT_LIMIT - 1));

    // DRAIN watchdog and its sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt <= (state_q == S_DRAIN) ? wd_cnt + 16'd1 : '0;
            if (accept) begin
                timeout_err <= 1'b0;
            end else if (state_q == S_DRAIN && !(&pe_valid) && wd_expired && !abort) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

endmodule
